// File: rtl/debug_uart_pkg.sv
// Shared types and constants for the debug UART transmit controller.
// Latency/backpressure: none (types only).
package debug_uart_pkg;

    localparam int DEPTH_DEFAULT = 4;
    localparam int BUSY_TIMEOUT  = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/debug_uart_fifo.sv
// Circular byte FIFO: head is combinational from the read pointer, level updates on the push/pop edge.
// Push while full is taken only alongside a pop; flush clears pointers and level and beats push.
module debug_uart_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [7:0]             wr_data,
    output logic [7:0]             head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop) && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap to zero naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/debug_uart_tx_ctrl.sv
// Queues CPU debug bytes and hands them one at a time to uart_tx; byte written at edge N pulses uart_tx_en after edge N+1.
// Waits on uart_tx_busy between bytes; writes into a full queue without a same-edge pop are dropped and flagged.
module debug_uart_tx_ctrl
    import debug_uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   flush,
    input  logic                   clr_ovf,
    output logic                   uart_tx_en,
    output logic [7:0]             uart_tx_data,
    input  logic                   uart_tx_busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   tx_idle
);

    localparam int TW = $clog2(BUSY_TIMEOUT);

    state_t        state;
    state_t        state_nxt;
    logic          pop;
    logic          drop;
    logic [7:0]    head;
    logic [TW-1:0] wait_cnt;

    debug_uart_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .pop     (pop),
        .flush   (flush),
        .wr_data (wr_data),
        .head    (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    assign drop    = wr_en && full && !pop && !flush;
    assign tx_idle = empty && (state == IDLE) && !uart_tx_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A uart_tx that never raises busy is assumed to have taken the byte once the timeout expires.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && !uart_tx_busy) begin
                    pop       = 1'b1;
                    state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (uart_tx_busy)                            state_nxt = WAIT_DONE;
                else if (wait_cnt == TW'(BUSY_TIMEOUT - 1)) state_nxt = IDLE;
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt     <= '0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= 8'h00;
            overflow     <= 1'b0;
        end else begin
            wait_cnt   <= (state == WAIT_BUSY) ? wait_cnt + 1'b1 : '0;
            uart_tx_en <= pop;
            if (pop) uart_tx_data <= head;
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_debug_uart_tx_ctrl.sv
// Directed bench for debug_uart_tx_ctrl with a behavioural uart_tx busy model.
module tb_debug_uart_tx_ctrl;

    localparam int   DEPTH = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_tx_busy;
    logic [2:0] level;
    logic       full, empty, overflow, tx_idle;

    logic       busy_force = 1'b0;
    logic       busy_model = 1'b0;
    int         busy_len = 10;
    int         busy_cnt = 0;
    logic [7:0] sent [$];

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic       wr;
        logic [7:0] data;
        logic       fl;
        logic       clr;
        logic [2:0] lvl;
        logic       ful;
        logic       emp;
        logic       ovf;
    } vec_t;

    vec_t vecs [16];

    always #5 clk = ~clk;

    assign uart_tx_busy = (busy_model & ~rst) | busy_force;

    debug_uart_tx_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .flush        (flush),
        .clr_ovf      (clr_ovf),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .tx_idle      (tx_idle)
    );

    // uart_tx model: logs each start pulse, raises busy for busy_len cycles (never when busy_len is 0).
    always @(negedge clk) begin
        if (rst) begin
            busy_model = 1'b0;
            busy_cnt   = 0;
        end else begin
            if (uart_tx_en) sent.push_back(uart_tx_data);
            if (busy_model) begin
                busy_cnt = busy_cnt - 1;
                if (busy_cnt == 0) busy_model = 1'b0;
            end else if (uart_tx_en && busy_len > 0) begin
                busy_model = 1'b1;
                busy_cnt   = busy_len;
            end
        end
    end

    function automatic vec_t v(logic wr, logic [7:0] d, logic fl, logic clr,
                               logic [2:0] lvl, logic ful, logic emp, logic ovf);
        vec_t r;
        r.wr = wr; r.data = d; r.fl = fl; r.clr = clr;
        r.lvl = lvl; r.ful = ful; r.emp = emp; r.ovf = ovf;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(string name, int max);
        int n = 0;
        while (!tx_idle && n < max) begin
            tick();
            n++;
        end
        check({name, " idle"}, {31'd0, tx_idle}, 32'd1);
    endtask

    // bytes holds the expected sequence with the first byte sent in the low byte.
    task automatic check_sent(string name, int n, logic [63:0] bytes);
        check({name, " count"}, sent.size(), n);
        for (int i = 0; i < n && i < sent.size(); i++)
            check($sformatf("%s byte%0d", name, i), {24'd0, sent[i]}, {24'd0, bytes[8*i +: 8]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int quiet;

        //           wr  data   fl clr  lvl   ful emp ovf
        vecs[0]  = v(H, 8'h11, L, L, 3'd1, L, L, L);
        vecs[1]  = v(H, 8'h22, L, L, 3'd2, L, L, L);
        vecs[2]  = v(H, 8'h33, L, L, 3'd3, L, L, L);
        vecs[3]  = v(H, 8'h44, L, L, 3'd4, H, L, L);
        vecs[4]  = v(H, 8'h99, L, L, 3'd4, H, L, H);
        vecs[5]  = v(H, 8'h98, L, H, 3'd4, H, L, H);
        vecs[6]  = v(L, 8'h00, L, H, 3'd4, H, L, L);
        vecs[7]  = v(L, 8'h00, L, L, 3'd4, H, L, L);
        vecs[8]  = v(H, 8'h77, H, L, 3'd0, L, H, L);
        vecs[9]  = v(H, 8'h12, L, L, 3'd1, L, L, L);
        vecs[10] = v(H, 8'h13, L, L, 3'd2, L, L, L);
        vecs[11] = v(H, 8'h14, L, L, 3'd3, L, L, L);
        vecs[12] = v(H, 8'h15, L, L, 3'd4, H, L, L);
        vecs[13] = v(H, 8'h16, L, L, 3'd4, H, L, H);
        vecs[14] = v(H, 8'h17, H, L, 3'd0, L, H, H);
        vecs[15] = v(L, 8'h00, L, H, 3'd0, L, H, L);

        // Reset values
        repeat (2) tick();
        check("reset", {level, full, empty, overflow, uart_tx_en, uart_tx_data, tx_idle},
                       {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1});
        busy_force = 1'b1;
        rst = 1'b0;
        tick();

        // Queue/overflow/flush table with the transmitter held busy so nothing pops
        for (int i = 0; i < 16; i++) begin
            wr_en   = vecs[i].wr;
            wr_data = vecs[i].data;
            flush   = vecs[i].fl;
            clr_ovf = vecs[i].clr;
            tick();
            check($sformatf("vec%0d", i), {level, full, empty, overflow, uart_tx_en},
                  {vecs[i].lvl, vecs[i].ful, vecs[i].emp, vecs[i].ovf, 1'b0});
        end
        wr_en = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
        busy_force = 1'b0;
        repeat (5) tick();
        check("flushed bytes not sent", sent.size(), 0);

        // Single byte latency and handshake
        busy_len = 10; sent.delete();
        write_byte(8'h41);
        check("A edge N", {uart_tx_en, level}, {1'b0, 3'd1});
        tick();
        check("A pulse", {uart_tx_en, uart_tx_data}, {1'b1, 8'h41});
        tick();
        check("A one-shot", {uart_tx_en, tx_idle}, {1'b0, 1'b0});
        wait_idle("A", 40);
        check_sent("A", 1, 64'h41);

        // Back-to-back burst overflows a 4-deep queue
        busy_len = 20; sent.delete();
        for (int i = 1; i <= 6; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        check("B overflow", {overflow, level}, {1'b1, 3'd4});
        wait_idle("B", 300);
        check_sent("B", 5, 64'h05_04_03_02_01);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("B clr_ovf", {31'd0, overflow}, 32'd0);

        // Write into a full queue on the pop edge
        busy_len = 3; sent.delete(); busy_force = 1'b1;
        for (int i = 0; i < 4; i++) write_byte(8'(8'hA1 + i));
        check("C fill", {full, level}, {1'b1, 3'd4});
        busy_force = 1'b0;
        write_byte(8'h55);
        check("C pop edge", {uart_tx_en, uart_tx_data, level, full, overflow},
                            {1'b1, 8'hA1, 3'd4, 1'b1, 1'b0});
        wait_idle("C", 100);
        check_sent("C", 5, 64'h55_A4_A3_A2_A1);

        // Flush with a byte in flight
        busy_len = 10; sent.delete();
        for (int i = 0; i < 3; i++) write_byte(8'(8'h31 + i));
        check("D queued", {31'd0, level == 3'd2}, 32'd1);
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        check("D flush", {level, empty, overflow}, {3'd0, 1'b1, 1'b0});
        wait_idle("D", 40);
        repeat (10) tick();
        check_sent("D", 1, 64'h31);

        // Busy never asserts: four cycles in WAIT_BUSY, then the next byte goes
        busy_len = 0; sent.delete();
        write_byte(8'h61);
        write_byte(8'h62);
        check("E first", {uart_tx_en, uart_tx_data, level}, {1'b1, 8'h61, 3'd1});
        quiet = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (uart_tx_en) quiet++;
        end
        check("E timeout gap", quiet, 0);
        tick();
        check("E second", {uart_tx_en, uart_tx_data}, {1'b1, 8'h62});
        wait_idle("E", 20);
        check_sent("E", 2, 64'h62_61);

        // Reset during WAIT_DONE with two bytes queued
        busy_len = 30; sent.delete();
        for (int i = 0; i < 3; i++) write_byte(8'(8'h71 + i));
        repeat (3) tick();
        check("F queued", {29'd0, level}, 32'd2);
        rst = 1'b1;
        #1;
        check("F in reset", {level, full, empty, overflow, uart_tx_en, uart_tx_data, tx_idle},
                            {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1});
        repeat (2) tick();
        rst = 1'b0;
        repeat (40) tick();
        check_sent("F", 1, 64'h71);
        write_byte(8'h7A);
        wait_idle("F new", 60);
        check_sent("F new", 2, 64'h7A_71);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/debug_uart_tx_ctrl.md
DEBUG_UART_TX_CTRL -- requirements
Module: debug_uart_tx_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; a power of two, minimum 2.
REQ-002 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1; one clock; reset is asynchronous and active-high.
REQ-004 Port wr_en, input, 1, CPU byte-write strobe (write to the debug UART data address).
REQ-005 Port wr_data, input, 8, byte to enqueue.
REQ-006 Port flush, input, 1, discards all queued bytes.
REQ-007 Port clr_ovf, input, 1, clears overflow.
REQ-008 Port uart_tx_en, output, 1, one-cycle start pulse to uart_tx.
REQ-009 Port uart_tx_data, output, 8, byte presented with uart_tx_en.
REQ-010 Port uart_tx_busy, input, 1, busy flag from uart_tx.
REQ-011 Port level, output, $clog2(DEPTH)+1, queued byte count.
REQ-012 Port full / empty, outputs, 1 each, level==DEPTH / level==0.
REQ-013 Port overflow, output, 1, sticky: a write was dropped.
REQ-014 Port tx_idle, output, 1, high when empty, FSM in IDLE and uart_tx_busy low.

Function
REQ-015 The FIFO SHALL be circular; read/write pointers wrap DEPTH-1 -> 0.
REQ-016 wr_en while level<DEPTH SHALL enqueue wr_data; level updates on the same edge.
REQ-017 wr_en while full SHALL be accepted only if a pop occurs on that edge; otherwise drop the byte and set overflow.
REQ-018 Simultaneous push and pop SHALL leave level unchanged.
REQ-019 The FSM SHALL have states IDLE, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE with !empty and uart_tx_busy low: pop head, register uart_tx_en=1 and uart_tx_data=head, go WAIT_BUSY.
REQ-021 uart_tx_en SHALL be high for exactly one cycle per popped byte; uart_tx_data holds the popped byte until the next pop.
REQ-022 WAIT_BUSY: on uart_tx_busy=1 go WAIT_DONE; if busy not seen within 4 cycles return to IDLE (byte counted sent).
REQ-023 WAIT_DONE: on uart_tx_busy=0 go IDLE.
REQ-024 Latency: byte written at edge N into an empty FIFO with FSM idle SHALL produce uart_tx_en high in the cycle after edge N+1.
REQ-025 flush SHALL zero level and both pointers on the next edge; an in-flight byte SHALL NOT be aborted (FSM continues its sequence).
REQ-026 flush and wr_en together: flush wins, byte dropped, overflow unchanged.
REQ-027 clr_ovf SHALL clear overflow; a new overflow on the same edge takes priority (stays set).
REQ-028 Bytes SHALL leave in write order with no duplication or loss except per REQ-017/025.

Reset
REQ-029 While rst high: state IDLE, pointers and level 0, empty=1, full=0, overflow=0, uart_tx_en=0, uart_tx_data=0x00, tx_idle follows REQ-014.
REQ-030 rst asserted mid-transmission SHALL discard the FIFO and return to IDLE immediately; no further uart_tx_en until a new write.

Structure
REQ-031 Package debug_uart_pkg SHALL hold the FSM state enum, DEPTH default and the busy timeout constant (4).
REQ-032 Storage and pointers SHALL live in one sub-module, debug_uart_fifo; FSM and overflow logic in the top.

Verification
REQ-033 Write 0x41 into idle block, busy model 10 cycles -> uart_tx_en one pulse in cycle after edge N+1, data 0x41, tx_idle high after busy drops.
REQ-034 Write 0x01..0x06 back-to-back, DEPTH=4, busy held 20 cycles per byte -> 0x01..0x05 sent in order, 0x06 dropped, overflow=1; clr_ovf -> 0.
REQ-035 Fill to 4 bytes, write 0x55 on the pop edge -> accepted, level stays 4, overflow 0.
REQ-036 Three bytes queued, first in flight, flush with write 0x77 -> in-flight byte completes, level 0, 0x77 never sent, no further tx_en.
REQ-037 Busy never asserts -> FSM returns to IDLE after 4 cycles and sends the next byte.
REQ-038 Assert rst during WAIT_DONE with 2 bytes queued -> outputs at reset values, no tx_en after release until a new write.
